floppy_seek_ctrl: RTL and testbench
===================================

# floppy_seek_ctrl

Type-I command sequencer for the floppy drive model. It accepts restore, seek and single-step commands from the controller side and spins the motor up on index pulses. It then drives `step_in`/`step_out` pulses at a programmed step rate, waits for head settle, and keeps the logical track register. It sits between the FDC command decoder and the floppy drive model.

## Interface
- `SYS_CLK`, default 8000000: system clock frequency in Hz; every timing below derives from it.
- `MAX_TRACK`, default 84: highest track number; seek targets are clamped to it.

- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  command request
- `cmd_ready`  out  1  high only in IDLE; a command is accepted on `cmd_valid && cmd_ready`
- `cmd_op`  in  2  operation: 0 restore, 1 seek, 2 step toward track 0, 3 step away from track 0
- `cmd_target`  in  7  seek target, used by op 1 only
- `rate_sel`  in  2  step rate: 0 = 6 ms, 1 = 12 ms, 2 = 20 ms, 3 = 30 ms
- `fd_track`  in  7  physical track under the head, from the drive
- `fd_ready`  in  1  drive ready: full speed and no step in progress
- `fd_index`  in  1  index signal, low for the pulse duration
- `step_in`  out  1  step pulse; the drive moves the head toward track 0 on its rising edge
- `step_out`  out  1  step pulse; the drive moves the head away from track 0 on its rising edge
- `motor_on`  out  1  motor enable to the drive
- `busy`  out  1  command in progress
- `done`  out  1  one-cycle completion strobe
- `err`  out  1  restore failure flag, valid with `done` and held until the next accept
- `track_reg`  out  7  logical track register

## Operation
- **Accept.** On accept, latch `cmd_op`, `cmd_target` and `rate_sel` and clear `err`.
  - `cmd_target` is clamped to `MAX_TRACK`.
  - The step period in cycles is (SYS_CLK/1000) × ms for the latched rate.
- **States:**
  - IDLE
  - SPINUP
  - DECIDE
  - PULSE
  - STEPWAIT
  - SETTLE
  - DONE
- **IDLE.** On accept, go to DECIDE if `motor_on` is already high. Otherwise set `motor_on` and go to SPINUP.
- **SPINUP.** Count falling edges of `fd_index` (registered edge detect). On the 6th edge, go to DECIDE.
- **DECIDE:**
  - Restore, `fd_track == 0`: `track_reg <= 0`, go to SETTLE.
  - Restore, otherwise: if the restore step count equals 255, set `err` and go to DONE. Otherwise increment the count, select `step_in`, go to PULSE.
  - Seek, `track_reg == target`: go to SETTLE.
  - Seek, `target > track_reg`: select `step_out`, increment `track_reg`.
  - Seek, `target < track_reg`: select `step_in`, decrement `track_reg`.
  - Op 2: if `fd_track == 0`, `track_reg <= 0` and go to SETTLE. Otherwise select `step_in` and decrement `track_reg` saturating at 0.
  - Op 3: select `step_out` and increment `track_reg` saturating at `MAX_TRACK`. The pulse is issued even at `MAX_TRACK`.
  - For ops 2 and 3, a flag makes the return from STEPWAIT go to SETTLE instead of DECIDE.
- **PULSE.** Assert the selected step line for STEP_PULSE_CLKS = 4 × SYS_CLK/1000000 cycles, then go to STEPWAIT.
- **STEPWAIT.** Wait until the step period has elapsed, measured from the first cycle of the pulse. Then go to DECIDE, or to SETTLE for single-step ops.
- **SETTLE.** Wait for `fd_ready` high, then go to DONE.
- **DONE.** Assert `done` for one cycle, then return to IDLE.
- **Motor timeout.** In IDLE with `motor_on` high, count falling edges of `fd_index`. On the 10th, clear `motor_on`. The count clears on any accept.
- **Step-line exclusivity.** `step_in` and `step_out` are never high in the same cycle.

## Timing
- **Reset values:** every output is 0 (`cmd_ready` is high from the cycle after reset). All counters are cleared and the state is IDLE.
- **Reset mid-operation:** a step line drops in the cycle after `reset` is sampled high, and no partial command completes.
- **Busy:** `busy` is high from the cycle after accept through SETTLE. It is low in DONE and IDLE.
- **Done/ready ordering:** `cmd_ready` rises the cycle after `done`.
- **Track register update:** `track_reg` updates in the DECIDE cycle that starts the pulse.
- **Counter widths:** counters are 32 bits wide; the step count is 8 bits.
- **Inputs held in IDLE:** `cmd_valid` held high during a command has no effect until IDLE.
- **Index edges outside SPINUP and IDLE:** ignored.
- **Seek to the current track with the motor already on:** DECIDE → SETTLE → DONE, with no step pulse.

## Test plan
- **Seek 0→5:** `SYS_CLK` 8 MHz, motor on, `rate_sel` 0, seek to 5. Required: exactly 5 `step_out` pulses of 32 cycles each, rising edges 48000 cycles apart; `track_reg` = 5; `done` after `fd_ready` returns high; `err` = 0.
- **Restore from track 3:** drive model at track 3, restore. Required: 3 `step_in` pulses; `track_reg` = 0; `err` = 0.
- **Spin-up:** motor off, seek to 2, `fd_index` toggled. Required: `motor_on` rises the cycle after accept; no step pulse before the 6th falling edge of `fd_index`.
- **Motor timeout:** idle with motor on. Required: `motor_on` clears on the 10th falling edge of `fd_index`; an accept after the 9th edge keeps it on.
- **Restore failure:** `fd_track` forced to 7, restore. Required: 255 `step_in` pulses, then `done` with `err` = 1.
- **Reset mid-pulse:** assert `reset` during PULSE. Required: step line, `busy` and `motor_on` are 0 and `track_reg` is 0 the next cycle; `cmd_ready` is 1 after reset releases.

Source files
------------

// File: rtl/floppy_seek_ctrl_if.sv
// Command-side bundle between the FDC command decoder (master) and the
// Type-I seek sequencer (slave).
interface floppy_seek_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [6:0] cmd_target;
  logic [1:0] rate_sel;
  logic       busy;
  logic       done;
  logic       err;
  logic [6:0] track_reg;

  modport master (
    output cmd_valid, cmd_op, cmd_target, rate_sel,
    input  cmd_ready, busy, done, err, track_reg
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_target, rate_sel,
    output cmd_ready, busy, done, err, track_reg
  );
endinterface

// File: rtl/floppy_seek_ctrl.sv
// Type-I command sequencer: restore / seek / single step with motor spin-up,
// step-rate timing, head settle and the logical track register.
module floppy_seek_ctrl #(
  parameter int unsigned SYS_CLK   = 8000000,
  parameter int unsigned MAX_TRACK = 84
) (
  input  logic               clk,
  input  logic               reset,
  floppy_seek_ctrl_if.slave  cmd,
  input  logic [6:0]         fd_track,
  input  logic               fd_ready,
  input  logic               fd_index,
  output logic               step_in,
  output logic               step_out,
  output logic               motor_on
);

  localparam logic [31:0] ClksPerMs = 32'(SYS_CLK / 1000);
  localparam int unsigned PulseRaw  = 4 * SYS_CLK / 1000000;
  // Slow clocks would round the pulse to zero cycles; keep at least one.
  localparam logic [31:0] PulseClks = (PulseRaw == 0) ? 32'd1 : 32'(PulseRaw);
  localparam logic [6:0]  MaxTrack  = 7'(MAX_TRACK);

  localparam logic [1:0] OpRestore = 2'd0;
  localparam logic [1:0] OpSeek    = 2'd1;
  localparam logic [1:0] OpStepIn  = 2'd2;
  localparam logic [1:0] OpStepOut = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StSpinup,
    StDecide,
    StPulse,
    StStepWait,
    StSettle,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic        ready_q, ready_d;
  logic        motor_q, motor_d;
  logic [1:0]  op_q, op_d;
  logic [6:0]  target_q, target_d;
  logic [1:0]  rate_q, rate_d;
  logic [6:0]  track_q, track_d;
  logic        err_q, err_d;
  logic [7:0]  rst_cnt_q, rst_cnt_d;
  logic [31:0] spin_cnt_q, spin_cnt_d;
  logic [31:0] idle_cnt_q, idle_cnt_d;
  logic [31:0] tmr_q, tmr_d;
  logic        dir_out_q, dir_out_d;
  logic        single_q, single_d;
  logic        idx_q;

  logic        accept;
  logic        idx_fall;
  logic [31:0] period;

  assign accept   = cmd.cmd_valid && ready_q;
  assign idx_fall = idx_q && !fd_index;

  always_comb begin
    unique case (rate_q)
      2'd0: period = ClksPerMs * 32'd6;
      2'd1: period = ClksPerMs * 32'd12;
      2'd2: period = ClksPerMs * 32'd20;
      2'd3: period = ClksPerMs * 32'd30;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    motor_d    = motor_q;
    op_d       = op_q;
    target_d   = target_q;
    rate_d     = rate_q;
    track_d    = track_q;
    err_d      = err_q;
    rst_cnt_d  = rst_cnt_q;
    spin_cnt_d = spin_cnt_q;
    idle_cnt_d = idle_cnt_q;
    tmr_d      = tmr_q;
    dir_out_d  = dir_out_q;
    single_d   = single_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d       = cmd.cmd_op;
          target_d   = (cmd.cmd_target > MaxTrack) ? MaxTrack : cmd.cmd_target;
          rate_d     = cmd.rate_sel;
          err_d      = 1'b0;
          rst_cnt_d  = '0;
          spin_cnt_d = '0;
          idle_cnt_d = '0;
          single_d   = 1'b0;
          motor_d    = 1'b1;
          state_d    = motor_q ? StDecide : StSpinup;
        end else if (motor_q && idx_fall) begin
          if (idle_cnt_q == 32'd9) begin
            motor_d    = 1'b0;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + 32'd1;
          end
        end
      end
      StSpinup: begin
        if (idx_fall) begin
          spin_cnt_d = spin_cnt_q + 32'd1;
          if (spin_cnt_q == 32'd5) state_d = StDecide;
        end
      end
      StDecide: begin
        // The step period is timed from the first pulse cycle.
        tmr_d = '0;
        unique case (op_q)
          OpRestore: begin
            if (fd_track == 7'd0) begin
              track_d = '0;
              state_d = StSettle;
            end else if (rst_cnt_q == 8'hff) begin
              err_d   = 1'b1;
              state_d = StDone;
            end else begin
              rst_cnt_d = rst_cnt_q + 8'd1;
              dir_out_d = 1'b0;
              state_d   = StPulse;
            end
          end
          OpSeek: begin
            if (track_q == target_q) begin
              state_d = StSettle;
            end else if (target_q > track_q) begin
              dir_out_d = 1'b1;
              track_d   = track_q + 7'd1;
              state_d   = StPulse;
            end else begin
              dir_out_d = 1'b0;
              track_d   = track_q - 7'd1;
              state_d   = StPulse;
            end
          end
          OpStepIn: begin
            if (fd_track == 7'd0) begin
              track_d = '0;
              state_d = StSettle;
            end else begin
              dir_out_d = 1'b0;
              single_d  = 1'b1;
              track_d   = (track_q == 7'd0) ? 7'd0 : track_q - 7'd1;
              state_d   = StPulse;
            end
          end
          OpStepOut: begin
            dir_out_d = 1'b1;
            single_d  = 1'b1;
            track_d   = (track_q >= MaxTrack) ? track_q : track_q + 7'd1;
            state_d   = StPulse;
          end
        endcase
      end
      StPulse: begin
        tmr_d = tmr_q + 32'd1;
        if (tmr_q >= PulseClks - 32'd1) state_d = StStepWait;
      end
      StStepWait: begin
        tmr_d = tmr_q + 32'd1;
        // Leave one cycle early so the DECIDE cycle completes the period.
        if (tmr_q >= period - 32'd2) state_d = single_q ? StSettle : StDecide;
      end
      StSettle: begin
        if (fd_ready) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      ready_q    <= 1'b0;
      motor_q    <= 1'b0;
      op_q       <= '0;
      target_q   <= '0;
      rate_q     <= '0;
      track_q    <= '0;
      err_q      <= 1'b0;
      rst_cnt_q  <= '0;
      spin_cnt_q <= '0;
      idle_cnt_q <= '0;
      tmr_q      <= '0;
      dir_out_q  <= 1'b0;
      single_q   <= 1'b0;
      idx_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      motor_q    <= motor_d;
      op_q       <= op_d;
      target_q   <= target_d;
      rate_q     <= rate_d;
      track_q    <= track_d;
      err_q      <= err_d;
      rst_cnt_q  <= rst_cnt_d;
      spin_cnt_q <= spin_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      tmr_q      <= tmr_d;
      dir_out_q  <= dir_out_d;
      single_q   <= single_d;
      idx_q      <= fd_index;
    end
  end

  assign cmd.cmd_ready = ready_q;
  assign cmd.busy      = (state_q != StIdle) && (state_q != StDone);
  assign cmd.done      = (state_q == StDone);
  assign cmd.err       = err_q;
  assign cmd.track_reg = track_q;
  assign step_in       = (state_q == StPulse) && !dir_out_q;
  assign step_out      = (state_q == StPulse) && dir_out_q;
  assign motor_on      = motor_q;

endmodule

// File: tb/tb_floppy_seek_ctrl.sv
// Bench for floppy_seek_ctrl: drive model, pulse monitor and a track/timing
// reference computed from the command rules.
module tb_floppy_seek_ctrl;
  localparam int unsigned SYS_CLK   = 20000;
  localparam int unsigned MAX_TRACK = 84;
  localparam int CLKS_PER_MS = SYS_CLK / 1000;
  localparam int PULSE_RAW   = 4 * SYS_CLK / 1000000;
  localparam int PULSE_CLKS  = (PULSE_RAW < 1) ? 1 : PULSE_RAW;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] fd_track;
  logic       fd_ready;
  logic       fd_index;
  logic       step_in, step_out, motor_on;

  floppy_seek_ctrl_if cmd_bus();

  floppy_seek_ctrl #(.SYS_CLK(SYS_CLK), .MAX_TRACK(MAX_TRACK)) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd      (cmd_bus),
    .fd_track (fd_track),
    .fd_ready (fd_ready),
    .fd_index (fd_index),
    .step_in  (step_in),
    .step_out (step_out),
    .motor_on (motor_on)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int model_track = 0;

  function automatic int period_of(input int r);
    int ms_tab [4] = '{6, 12, 20, 30};
    return CLKS_PER_MS * ms_tab[r];
  endfunction

  // Drive model: head moves on step rising edges, ready drops while settling.
  int   phys = 0;
  int   rdy_cnt = 0;
  int   settle_clks = 10;
  int   set_val = 0;
  logic set_req = 1'b0;
  logic force7 = 1'b0;
  logic si_d = 1'b0, so_d = 1'b0;
  always @(posedge clk) begin
    si_d <= step_in;
    so_d <= step_out;
    if (set_req) phys <= set_val;
    else if (step_in && !si_d) phys <= (phys > 0) ? phys - 1 : 0;
    else if (step_out && !so_d) phys <= (phys < 127) ? phys + 1 : 127;
    if ((step_in && !si_d) || (step_out && !so_d)) rdy_cnt <= settle_clks;
    else if (rdy_cnt > 0) rdy_cnt <= rdy_cnt - 1;
  end
  assign fd_track = force7 ? 7'd7 : 7'(phys);
  assign fd_ready = (rdy_cnt == 0);

  int   so_cnt = 0, si_cnt = 0, done_cnt = 0, excl_bad = 0;
  int   w_in = 0, w_out = 0;
  int   rises[$];
  int   widths[$];
  logic mi_d = 1'b0, mo_d = 1'b0;
  always @(negedge clk) begin
    if (step_in && step_out) excl_bad++;
    if (step_out && !mo_d) begin so_cnt++; rises.push_back(cyc); end
    if (step_in && !mi_d) begin si_cnt++; rises.push_back(cyc); end
    if (step_out) w_out++;
    else if (mo_d) begin widths.push_back(w_out); w_out = 0; end
    if (step_in) w_in++;
    else if (mi_d) begin widths.push_back(w_in); w_in = 0; end
    if (cmd_bus.done) done_cnt++;
    mi_d = step_in;
    mo_d = step_out;
  end

  logic got, done_err, done_rdy, done_busy, done_fdr;
  int   done_cyc, acc_cyc;

  task automatic wait_done(input int budget);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (cmd_bus.done) begin
        got = 1'b1; done_cyc = cyc; done_err = cmd_bus.err;
        done_rdy = cmd_bus.cmd_ready; done_busy = cmd_bus.busy; done_fdr = fd_ready;
      end
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [6:0] tgt, input logic [1:0] rate);
    @(negedge clk);
    rises.delete();
    widths.delete();
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_op = op;
    cmd_bus.cmd_target = tgt;
    cmd_bus.rate_sel = rate;
    for (int i = 0; i < 1000 && !cmd_bus.cmd_ready; i++) @(negedge clk);
    @(posedge clk);
    #1;
    cmd_bus.cmd_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic idx_pulse();
    @(negedge clk);
    fd_index = 1'b0;
    repeat (3) @(negedge clk);
    fd_index = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic set_phys(input int v);
    @(negedge clk);
    set_val = v;
    set_req = 1'b1;
    @(negedge clk);
    set_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cmd_bus.cmd_valid = 1'b0; cmd_bus.cmd_op = '0; cmd_bus.cmd_target = '0; cmd_bus.rate_sel = '0;
    fd_index = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({step_in, step_out, motor_on, cmd_bus.busy, cmd_bus.done, cmd_bus.err, cmd_bus.cmd_ready}
        !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want 0000000", {step_in, step_out, motor_on,
               cmd_bus.busy, cmd_bus.done, cmd_bus.err, cmd_bus.cmd_ready});
    end
    n_cmp++;
    if (cmd_bus.track_reg !== 7'd0) begin
      n_bad++; $display("FAIL reset_track: got %0d want 0", cmd_bus.track_reg);
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (cmd_bus.cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready: got %b want 1", cmd_bus.cmd_ready);
    end
  endtask

  task automatic test_spinup();
    issue(2'd1, 7'd2, 2'd0);
    @(negedge clk);
    n_cmp++;
    if ({motor_on, cmd_bus.busy} !== 2'b11) begin
      n_bad++; $display("FAIL spinup_motor_busy: got %b want 11", {motor_on, cmd_bus.busy});
    end
    repeat (5) idx_pulse();
    repeat (20) @(negedge clk);
    n_cmp++;
    if (so_cnt + si_cnt !== 0) begin
      n_bad++; $display("FAIL spinup_early_step: got %0d pulses want 0", so_cnt + si_cnt);
    end
    idx_pulse();
    wait_done(3000);
    n_cmp++;
    if (got !== 1'b1 || so_cnt !== 2 || cmd_bus.track_reg !== 7'd2 || done_err !== 1'b0) begin
      n_bad++;
      $display("FAIL spinup_seek: got done=%b steps=%0d track=%0d err=%b want 1/2/2/0",
               got, so_cnt, cmd_bus.track_reg, done_err);
    end
    model_track = 2;
  endtask

  task automatic test_restore3();
    int si0;
    logic [1:0] r;
    r = 2'($urandom_range(0, 3));
    set_phys(3);
    si0 = si_cnt;
    issue(2'd0, 7'd0, r);
    wait_done(4 * period_of(int'(r)) + 500);
    n_cmp++;
    if (got !== 1'b1 || si_cnt - si0 !== 3) begin
      n_bad++; $display("FAIL restore3_steps: got done=%b steps=%0d want 1/3", got, si_cnt - si0);
    end
    n_cmp++;
    if (cmd_bus.track_reg !== 7'd0 || done_err !== 1'b0) begin
      n_bad++; $display("FAIL restore3_track_err: got %0d/%b want 0/0", cmd_bus.track_reg, done_err);
    end
    model_track = 0;
  endtask

  task automatic test_seek_05();
    int so0;
    settle_clks = 300;
    so0 = so_cnt;
    issue(2'd1, 7'd5, 2'd0);
    wait_done(5 * period_of(0) + 1000);
    n_cmp++;
    if (got !== 1'b1 || so_cnt - so0 !== 5 || rises.size() !== 5) begin
      n_bad++; $display("FAIL seek05_count: got done=%b steps=%0d want 1/5", got, so_cnt - so0);
    end
    for (int i = 1; i < rises.size(); i++) begin
      n_cmp++;
      if (rises[i] - rises[i-1] !== period_of(0)) begin
        n_bad++;
        $display("FAIL seek05_spacing[%0d]: got %0d want %0d", i, rises[i] - rises[i-1],
                 period_of(0));
      end
    end
    foreach (widths[i]) begin
      n_cmp++;
      if (widths[i] !== PULSE_CLKS) begin
        n_bad++; $display("FAIL seek05_width[%0d]: got %0d want %0d", i, widths[i], PULSE_CLKS);
      end
    end
    n_cmp++;
    if (cmd_bus.track_reg !== 7'd5 || done_err !== 1'b0) begin
      n_bad++; $display("FAIL seek05_track_err: got %0d/%b want 5/0", cmd_bus.track_reg, done_err);
    end
    if (rises.size() == 5) begin
      n_cmp++;
      if (done_fdr !== 1'b1 || done_cyc - rises[4] < 300) begin
        n_bad++;
        $display("FAIL seek05_settle: got ready=%b gap=%0d want 1/>=300", done_fdr,
                 done_cyc - rises[4]);
      end
    end
    settle_clks = 10;
    model_track = 5;
  endtask

  task automatic test_random_seek();
    for (int it = 0; it < 4; it++) begin
      int tgt, r, n, so0, si0, exp_so, exp_si;
      tgt = $urandom_range(0, 8);
      r = $urandom_range(0, 3);
      settle_clks = $urandom_range(2, 40);
      n = (tgt > model_track) ? tgt - model_track : model_track - tgt;
      exp_so = (tgt > model_track) ? n : 0;
      exp_si = (tgt > model_track) ? 0 : n;
      so0 = so_cnt;
      si0 = si_cnt;
      issue(2'd1, 7'(tgt), 2'(r));
      wait_done(n * period_of(r) + 300);
      n_cmp++;
      if (got !== 1'b1 || so_cnt - so0 !== exp_so || si_cnt - si0 !== exp_si) begin
        n_bad++;
        $display("FAIL rand_seek[%0d]: got done=%b out=%0d in=%0d want 1/%0d/%0d", it, got,
                 so_cnt - so0, si_cnt - si0, exp_so, exp_si);
      end
      for (int i = 1; i < rises.size(); i++) begin
        n_cmp++;
        if (rises[i] - rises[i-1] !== period_of(r)) begin
          n_bad++;
          $display("FAIL rand_spacing[%0d]: got %0d want %0d", it, rises[i] - rises[i-1],
                   period_of(r));
        end
      end
      n_cmp++;
      if (cmd_bus.track_reg !== 7'(tgt)) begin
        n_bad++; $display("FAIL rand_track[%0d]: got %0d want %0d", it, cmd_bus.track_reg, tgt);
      end
      model_track = tgt;
    end
    settle_clks = 10;
  endtask

  task automatic test_single_step_clamp();
    int so0, si0, n;
    n = MAX_TRACK - model_track;
    so0 = so_cnt;
    issue(2'd1, 7'd127, 2'd0);
    wait_done(n * period_of(0) + 300);
    n_cmp++;
    if (got !== 1'b1 || so_cnt - so0 !== n || cmd_bus.track_reg !== 7'(MAX_TRACK)) begin
      n_bad++;
      $display("FAIL clamp_seek: got done=%b steps=%0d track=%0d want 1/%0d/%0d", got,
               so_cnt - so0, cmd_bus.track_reg, n, MAX_TRACK);
    end
    so0 = so_cnt;
    issue(2'd3, 7'd0, 2'd0);
    wait_done(period_of(0) + 300);
    n_cmp++;
    if (got !== 1'b1 || so_cnt - so0 !== 1 || cmd_bus.track_reg !== 7'(MAX_TRACK)) begin
      n_bad++;
      $display("FAIL step_out_at_max: got done=%b steps=%0d track=%0d want 1/1/%0d", got,
               so_cnt - so0, cmd_bus.track_reg, MAX_TRACK);
    end
    si0 = si_cnt;
    issue(2'd2, 7'd0, 2'd0);
    wait_done(period_of(0) + 300);
    n_cmp++;
    if (got !== 1'b1 || si_cnt - si0 !== 1 || cmd_bus.track_reg !== 7'(MAX_TRACK - 1)) begin
      n_bad++;
      $display("FAIL step_in: got done=%b steps=%0d track=%0d want 1/1/%0d", got,
               si_cnt - si0, cmd_bus.track_reg, MAX_TRACK - 1);
    end
    set_phys(0);
    si0 = si_cnt;
    so0 = so_cnt;
    issue(2'd2, 7'd0, 2'd0);
    wait_done(300);
    n_cmp++;
    if (got !== 1'b1 || si_cnt + so_cnt - si0 - so0 !== 0 || cmd_bus.track_reg !== 7'd0) begin
      n_bad++;
      $display("FAIL step_in_at_zero: got done=%b steps=%0d track=%0d want 1/0/0", got,
               si_cnt + so_cnt - si0 - so0, cmd_bus.track_reg);
    end
    model_track = 0;
  endtask

  task automatic test_seek_current();
    int p0;
    p0 = si_cnt + so_cnt;
    issue(2'd1, 7'(model_track), 2'($urandom_range(0, 3)));
    wait_done(20);
    n_cmp++;
    if (got !== 1'b1 || done_cyc - acc_cyc !== 2 || si_cnt + so_cnt !== p0) begin
      n_bad++;
      $display("FAIL seek_current: got done=%b latency=%0d pulses=%0d want 1/2/0", got,
               done_cyc - acc_cyc, si_cnt + so_cnt - p0);
    end
    n_cmp++;
    if ({done_busy, done_rdy} !== 2'b00) begin
      n_bad++; $display("FAIL done_busy_ready: got %b want 00", {done_busy, done_rdy});
    end
    @(negedge clk);
    n_cmp++;
    if ({cmd_bus.cmd_ready, cmd_bus.done} !== 2'b10) begin
      n_bad++; $display("FAIL ready_after_done: got %b want 10", {cmd_bus.cmd_ready, cmd_bus.done});
    end
  endtask

  task automatic test_restore_fail();
    int si0;
    force7 = 1'b1;
    si0 = si_cnt;
    issue(2'd0, 7'd0, 2'd0);
    wait_done(255 * period_of(0) + 500);
    n_cmp++;
    if (got !== 1'b1 || si_cnt - si0 !== 255 || done_err !== 1'b1) begin
      n_bad++;
      $display("FAIL restore_fail: got done=%b steps=%0d err=%b want 1/255/1", got,
               si_cnt - si0, done_err);
    end
    force7 = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (cmd_bus.err !== 1'b1) begin
      n_bad++; $display("FAIL err_held: got %b want 1", cmd_bus.err);
    end
  endtask

  task automatic test_motor_timeout();
    repeat (9) idx_pulse();
    n_cmp++;
    if (motor_on !== 1'b1) begin
      n_bad++; $display("FAIL timeout_9_edges: got %b want 1", motor_on);
    end
    issue(2'd1, 7'(model_track), 2'd0);
    wait_done(20);
    n_cmp++;
    if (got !== 1'b1 || done_err !== 1'b0) begin
      n_bad++; $display("FAIL err_cleared: got done=%b err=%b want 1/0", got, done_err);
    end
    repeat (9) idx_pulse();
    n_cmp++;
    if (motor_on !== 1'b1) begin
      n_bad++; $display("FAIL timeout_count_cleared: got %b want 1", motor_on);
    end
    @(negedge clk);
    fd_index = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (motor_on !== 1'b0) begin
      n_bad++; $display("FAIL timeout_10th_edge: got %b want 0", motor_on);
    end
    repeat (2) @(negedge clk);
    fd_index = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_pulse();
    int d0;
    logic seen;
    set_phys(0);
    issue(2'd1, 7'd5, 2'd0);
    repeat (6) idx_pulse();
    seen = step_out;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      seen = step_out;
    end
    n_cmp++;
    if (seen !== 1'b1) begin
      n_bad++; $display("FAIL midpulse_reached: got %b want 1", seen);
    end
    d0 = done_cnt;
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({step_in, step_out, cmd_bus.busy, motor_on, cmd_bus.done} !== 5'b0 ||
        cmd_bus.track_reg !== 7'd0) begin
      n_bad++;
      $display("FAIL midpulse_reset: got %b track=%0d want 00000 track=0",
               {step_in, step_out, cmd_bus.busy, motor_on, cmd_bus.done}, cmd_bus.track_reg);
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (cmd_bus.cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL midpulse_ready: got %b want 1", cmd_bus.cmd_ready);
    end
    repeat (400) @(negedge clk);
    n_cmp++;
    if (done_cnt !== d0 || cmd_bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL midpulse_no_complete: got done=%0d busy=%b want 0/0", done_cnt - d0,
               cmd_bus.busy);
    end
  endtask

  task automatic test_exclusivity();
    n_cmp++;
    if (excl_bad !== 0) begin
      n_bad++; $display("FAIL step_exclusive: got %0d overlap cycles want 0", excl_bad);
    end
  endtask

  initial begin
    test_reset();
    test_spinup();
    test_restore3();
    test_seek_05();
    test_random_seek();
    test_single_step_clamp();
    test_seek_current();
    test_restore_fail();
    test_motor_timeout();
    test_reset_mid_pulse();
    test_exclusivity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
